// File: rtl/wb_retire_trace_buffer.sv
// Retirement trace monitor: captures non-bubble WB-stage instructions into a FIFO
// drained over a valid/ready port, stopping once MAX_RETIRE instructions have retired.
module wb_retire_trace_buffer #(
   parameter int          DEPTH      = 16,
   parameter int          MAX_RETIRE = 1200,
   parameter logic [31:0] BUBBLE     = 32'hffffffff
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     trace_en,
   input  logic [31:0]              wb_pc,
   input  logic [31:0]              wb_ir,
   input  logic                     wb_rf_w,
   input  logic [4:0]               wb_rdc,
   input  logic [31:0]              wb_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_ir,
   output logic                     out_rf_w,
   output logic [4:0]               out_rdc,
   output logic [31:0]              out_wdata,
   output logic [15:0]              retired,
   output logic [$clog2(DEPTH):0]   used,
   output logic [15:0]              dropped,
   output logic                     overflow,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [15:0] MAX_W   = 16'(MAX_RETIRE);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [31:0] mem_pc    [DEPTH];
   logic [31:0] mem_ir    [DEPTH];
   logic        mem_rf_w  [DEPTH];
   logic [4:0]  mem_rdc   [DEPTH];
   logic [31:0] mem_wdata [DEPTH];

   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign capture = (state == ST_RUN) && (wb_ir != BUBBLE);
   assign full    = (used == DEPTH_W);
   assign pop     = out_valid && out_ready;
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   // Outputs are masked when empty so reset and drained states show all zeros.
   assign out_valid = (used != '0);
   assign out_pc    = out_valid ? mem_pc[rd_ptr] : 32'd0;
   assign out_ir    = out_valid ? mem_ir[rd_ptr] : 32'd0;
   assign out_rf_w  = out_valid && mem_rf_w[rd_ptr];
   assign out_rdc   = out_rf_w ? mem_rdc[rd_ptr] : 5'd0;
   assign out_wdata = out_rf_w ? mem_wdata[rd_ptr] : 32'd0;
   assign done      = (state == ST_DONE);

   always_ff @(posedge clk_in) begin
      if (push && !clear) begin
         mem_pc[wr_ptr]    <= wb_pc;
         mem_ir[wr_ptr]    <= wb_ir;
         mem_rf_w[wr_ptr]  <= wb_rf_w;
         mem_rdc[wr_ptr]   <= wb_rdc;
         mem_wdata[wr_ptr] <= wb_wdata;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         used     <= '0;
         retired  <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         used     <= '0;
         retired  <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            used <= used + 1'b1;
         else if (!push && pop)
            used <= used - 1'b1;

         // A dropped entry still counts as retired; only the trace record is lost.
         if (capture && retired != MAX_W)
            retired <= retired + 16'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (dropped != 16'hffff)
               dropped <= dropped + 16'd1;
         end

         case (state)
            ST_IDLE: if (trace_en) state <= ST_RUN;
            ST_RUN: begin
               if (capture && retired == MAX_W - 16'd1)
                  state <= ST_DONE;
               else if (!trace_en)
                  state <= ST_IDLE;
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_retire_trace_buffer.sv
// Randomized bench for wb_retire_trace_buffer with a queue-based reference model.
module tb_wb_retire_trace_buffer;

   localparam int          DEPTH      = 16;
   localparam int          MAX_RETIRE = 1200;
   localparam logic [31:0] BUBBLE     = 32'hffffffff;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        clear;
   logic        trace_en;
   logic [31:0] wb_pc;
   logic [31:0] wb_ir;
   logic        wb_rf_w;
   logic [4:0]  wb_rdc;
   logic [31:0] wb_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_ir;
   logic        out_rf_w;
   logic [4:0]  out_rdc;
   logic [31:0] out_wdata;
   logic [15:0] retired;
   logic [4:0]  used;
   logic [15:0] dropped;
   logic        overflow;
   logic        done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        rf_w;
      logic [4:0]  rdc;
      logic [31:0] wdata;
   } entry_t;

   typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

   entry_t  q[$];
   mstate_t m_state;
   int      m_retired;
   int      m_dropped;
   bit      m_overflow;

   wb_retire_trace_buffer #(
      .DEPTH(DEPTH), .MAX_RETIRE(MAX_RETIRE), .BUBBLE(BUBBLE)
   ) dut (
      .clk_in(clk_in), .reset(reset), .clear(clear), .trace_en(trace_en),
      .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_rf_w(wb_rf_w), .wb_rdc(wb_rdc),
      .wb_wdata(wb_wdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_ir(out_ir), .out_rf_w(out_rf_w), .out_rdc(out_rdc),
      .out_wdata(out_wdata), .retired(retired), .used(used), .dropped(dropped),
      .overflow(overflow), .done(done)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] rand_instr();
      logic [31:0] v;
      v = $urandom;
      if (v == BUBBLE) v = 32'h00000013;
      return v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_state    = M_IDLE;
      m_retired  = 0;
      m_dropped  = 0;
      m_overflow = 0;
   endtask

   task automatic set_wb(input logic [31:0] pc, input logic [31:0] ir, input logic rf_w,
                         input logic [4:0] rdc, input logic [31:0] wdata);
      wb_pc = pc; wb_ir = ir; wb_rf_w = rf_w; wb_rdc = rdc; wb_wdata = wdata;
   endtask

   task automatic set_bubble();
      set_wb($urandom, BUBBLE, $urandom_range(0, 1), 5'($urandom), $urandom);
   endtask

   // Advance the reference model with the inputs currently driven, then clock the DUT.
   task automatic apply_stimulus();
      bit     do_pop, cap, full;
      entry_t e;
      if (clear) begin
         model_reset();
      end else begin
         do_pop = (q.size() != 0) && out_ready;
         cap    = (m_state == M_RUN) && (wb_ir != BUBBLE);
         full   = (q.size() == DEPTH);
         if (do_pop) void'(q.pop_front());
         if (cap) begin
            if (!full || do_pop) begin
               e.pc = wb_pc; e.ir = wb_ir; e.rf_w = wb_rf_w; e.rdc = wb_rdc; e.wdata = wb_wdata;
               q.push_back(e);
            end else begin
               if (m_dropped < 16'hffff) m_dropped++;
               m_overflow = 1;
            end
            if (m_retired < MAX_RETIRE) m_retired++;
         end
         if (m_state == M_IDLE && trace_en) m_state = M_RUN;
         else if (m_state == M_RUN) begin
            if (cap && m_retired == MAX_RETIRE) m_state = M_DONE;
            else if (!trace_en) m_state = M_IDLE;
         end
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_clear_and_arm();
      clear = 1'b1; trace_en = 1'b0; out_ready = 1'b0; set_bubble();
      apply_stimulus();
      clear = 1'b0; trace_en = 1'b1;
      apply_stimulus();
   endtask

   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; trace_en = 1'b0; out_ready = 1'b0; set_bubble();
      model_reset();
      @(posedge clk_in); @(posedge clk_in); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0b exp 0", out_valid); end
      checks++; if (used !== 5'd0 || retired !== 16'd0 || dropped !== 16'd0) begin
         errors++; $display("[TB] FAIL rst_counts used %0d retired %0d dropped %0d exp 0", used, retired, dropped); end
      checks++; if (overflow !== 1'b0 || done !== 1'b0 || out_pc !== 32'd0) begin
         errors++; $display("[TB] FAIL rst_flags ovf %0b done %0b pc %h exp 0", overflow, done, out_pc); end
      #2 reset = 1'b1;
      @(posedge clk_in); #1;
      trace_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_bubble();
         apply_stimulus();
         checks++; if (out_valid !== 1'b0 || used !== 5'd0 || retired !== 16'd0) begin
            errors++; $display("[TB] FAIL bubble_only valid %0b used %0d retired %0d exp 0", out_valid, used, retired); end
      end
   endtask

   task automatic test_in_order();
      logic [31:0] pcs [3];
      pcs[0] = 32'h00400000; pcs[1] = 32'h00400004; pcs[2] = 32'h00400008;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_wb(pcs[i], rand_instr(), 1'b1, 5'($urandom), $urandom);
         apply_stimulus();
         checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i]) begin
            errors++; $display("[TB] FAIL in_order_%0d valid %0b pc %h exp 1 %h", i, out_valid, out_pc, pcs[i]); end
         checks++; if (out_ir !== q[0].ir || out_wdata !== q[0].wdata) begin
            errors++; $display("[TB] FAIL in_order_data_%0d ir %h wdata %h exp %h %h", i, out_ir, out_wdata, q[0].ir, q[0].wdata); end
      end
      set_bubble();
      apply_stimulus();
      checks++; if (retired !== 16'd3 || used !== 5'd0 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL in_order_end retired %0d used %0d valid %0b exp 3 0 0", retired, used, out_valid); end
   endtask

   task automatic test_overflow();
      do_clear_and_arm();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_wb(32'h00001000 + 32'(4*i), rand_instr(), 1'b1, 5'($urandom), $urandom);
         apply_stimulus();
      end
      trace_en = 1'b0; set_bubble();
      apply_stimulus();
      checks++; if (used !== 5'd16 || dropped !== 16'd4 || overflow !== 1'b1 || retired !== 16'd20) begin
         errors++; $display("[TB] FAIL overflow used %0d dropped %0d ovf %0b retired %0d exp 16 4 1 20", used, dropped, overflow, retired); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h00001000 + 32'(4*i)) begin
            errors++; $display("[TB] FAIL overflow_drain_%0d valid %0b pc %h exp 1 %h", i, out_valid, out_pc, 32'h00001000 + 32'(4*i)); end
         apply_stimulus();
      end
      checks++; if (out_valid !== 1'b0 || used !== 5'd0) begin
         errors++; $display("[TB] FAIL overflow_empty valid %0b used %0d exp 0 0", out_valid, used); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] order[$];
      do_clear_and_arm();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_wb(32'h00002000 + 32'(4*i), rand_instr(), 1'b1, 5'($urandom), $urandom);
         order.push_back(wb_pc);
         apply_stimulus();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_wb(32'h00003000 + 32'(4*i), rand_instr(), 1'b0, 5'($urandom), $urandom);
         order.push_back(wb_pc);
         checks++; if (out_pc !== order[i]) begin
            errors++; $display("[TB] FAIL b2b_head_%0d pc %h exp %h", i, out_pc, order[i]); end
         apply_stimulus();
         checks++; if (used !== 5'd16 || dropped !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_full_%0d used %0d dropped %0d ovf %0b exp 16 0 0", i, used, dropped, overflow); end
      end
      set_bubble();
      for (int i = 8; i < 24; i++) begin
         checks++; if (out_pc !== order[i] || out_rf_w !== q[0].rf_w) begin
            errors++; $display("[TB] FAIL b2b_drain_%0d pc %h rf_w %0b exp %h %0b", i, out_pc, out_rf_w, order[i], q[0].rf_w); end
         apply_stimulus();
      end
      checks++; if (used !== 5'd0) begin errors++; $display("[TB] FAIL b2b_empty used %0d exp 0", used); end
   endtask

   task automatic test_retire_limit();
      do_clear_and_arm();
      out_ready = 1'b1;
      for (int n = 1; n <= MAX_RETIRE; n++) begin
         set_wb($urandom, rand_instr(), 1'($urandom), 5'($urandom), $urandom);
         apply_stimulus();
         checks++; if (done !== (m_state == M_DONE) || retired !== 16'(m_retired)) begin
            errors++; $display("[TB] FAIL limit_%0d done %0b retired %0d exp %0b %0d", n, done, retired, m_state == M_DONE, m_retired); end
      end
      checks++; if (done !== 1'b1 || retired !== 16'd1200) begin
         errors++; $display("[TB] FAIL limit_done done %0b retired %0d exp 1 1200", done, retired); end
      for (int i = 0; i < 5; i++) begin
         set_wb($urandom, rand_instr(), 1'b1, 5'($urandom), $urandom);
         apply_stimulus();
      end
      checks++; if (retired !== 16'd1200 || used !== 5'd0 || done !== 1'b1) begin
         errors++; $display("[TB] FAIL limit_ignore retired %0d used %0d done %0b exp 1200 0 1", retired, used, done); end
      clear = 1'b1; trace_en = 1'b0;
      apply_stimulus();
      clear = 1'b0;
      checks++; if (done !== 1'b0 || retired !== 16'd0 || dropped !== 16'd0 || used !== 5'd0 || overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL limit_clear done %0b retired %0d dropped %0d used %0d ovf %0b exp 0", done, retired, dropped, used, overflow); end
   endtask

   task automatic test_random();
      do_clear_and_arm();
      for (int i = 0; i < 400; i++) begin
         clear     = ($urandom_range(0, 99) == 0);
         trace_en  = ($urandom_range(0, 7) != 0);
         out_ready = 1'($urandom);
         if ($urandom_range(0, 9) < 3) set_bubble();
         else set_wb($urandom, rand_instr(), 1'($urandom), 5'($urandom), $urandom);
         apply_stimulus();
         checks++; if (used !== 5'(q.size()) || out_valid !== (q.size() != 0) || retired !== 16'(m_retired) ||
                       dropped !== 16'(m_dropped) || overflow !== m_overflow || done !== (m_state == M_DONE)) begin
            errors++; $display("[TB] FAIL rnd_state_%0d used %0d retired %0d dropped %0d ovf %0b done %0b exp %0d %0d %0d %0b %0b",
                               i, used, retired, dropped, overflow, done, q.size(), m_retired, m_dropped, m_overflow, m_state == M_DONE); end
         if (q.size() != 0) begin
            checks++; if (out_pc !== q[0].pc || out_ir !== q[0].ir || out_rf_w !== q[0].rf_w ||
                          out_rdc !== (q[0].rf_w ? q[0].rdc : 5'd0) || out_wdata !== (q[0].rf_w ? q[0].wdata : 32'd0)) begin
               errors++; $display("[TB] FAIL rnd_head_%0d pc %h ir %h rf_w %0b rdc %0d wdata %h exp %h %h %0b", i,
                                  out_pc, out_ir, out_rf_w, out_rdc, out_wdata, q[0].pc, q[0].ir, q[0].rf_w); end
         end
      end
      clear = 1'b0;
   endtask

   task automatic test_rf_mask_and_reset();
      do_clear_and_arm();
      out_ready = 1'b0;
      set_wb(32'h00005000, rand_instr(), 1'b0, 5'd9, 32'h00001234);
      apply_stimulus();
      checks++; if (out_valid !== 1'b1 || out_rf_w !== 1'b0 || out_rdc !== 5'd0 || out_wdata !== 32'd0) begin
         errors++; $display("[TB] FAIL rf_mask valid %0b rf_w %0b rdc %0d wdata %h exp 1 0 0 0", out_valid, out_rf_w, out_rdc, out_wdata); end
      for (int i = 0; i < 4; i++) begin
         set_wb($urandom, rand_instr(), 1'b1, 5'($urandom), $urandom);
         apply_stimulus();
      end
      checks++; if (used !== 5'd5) begin errors++; $display("[TB] FAIL pre_reset used %0d exp 5", used); end
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++; if (used !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || retired !== 16'd0) begin
         errors++; $display("[TB] FAIL async_reset used %0d valid %0b pc %h retired %0d exp 0", used, out_valid, out_pc, retired); end
      #2 reset = 1'b1;
      @(posedge clk_in); #1;
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_overflow();
      test_back_to_back();
      test_retire_limit();
      test_random();
      test_rf_mask_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
